// File: rtl/uart_fifo_core.sv
// Bus-attached UART: RX/TX circular byte FIFOs, sticky error flags and a
// level interrupt, with one-cycle registered acknowledge on a simple strobe bus.
module uart_fifo_core #(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        adr2_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        int_o
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

  function automatic logic [3:0] sat4(input logic [CW-1:0] c);
    logic [7:0] w;
    w = 8'(c);
    return (w > 8'd15) ? 4'hF : w[3:0];
  endfunction

  logic          r_ack;
  logic [31:0]   r_dat;
  logic          r_rx_ie, r_tx_ie, r_rx_ovr, r_frm_err, r_tx_ovf;

  logic [7:0]    r_rxf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rxf_wp, r_rxf_rp;
  logic [CW-1:0] r_rxf_cnt;
  logic [7:0]    r_txf_mem [FIFO_DEPTH];
  logic [AW-1:0] r_txf_wp, r_txf_rp;
  logic [CW-1:0] r_txf_cnt;

  logic          r_rx_p0, r_rx_p1, r_rx_p2;
  state_t        r_rx_st, w_rx_nx;
  logic [15:0]   r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;

  state_t        r_tx_st, w_tx_nx;
  logic [15:0]   r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh;
  logic          r_tx_o;

  logic          w_acc, w_wr, w_rd, w_ctl_wr, w_tx_push, w_rx_pop_req;
  logic          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_tx_idle;
  logic          w_rx_pop, w_tx_pop, w_rx_push, w_rx_frm, w_rx_sample;
  logic          w_rx_push_ok, w_tx_push_ok, w_rx_tick, w_tx_tick;
  logic          w_rx_line, w_tx_line;
  logic [2:0]    w_clr;
  logic [7:0]    w_rx_head, w_tx_head;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Bus decode: a strobe is accepted only while no acknowledge is pending.
  assign w_acc        = stb_i & ~r_ack;
  assign w_wr         = w_acc & we_i;
  assign w_rd         = w_acc & ~we_i;
  assign w_ctl_wr     = w_wr & adr2_i;
  assign w_tx_push    = w_wr & ~adr2_i & sel_i[3];
  assign w_rx_pop_req = w_rd & ~adr2_i & sel_i[3];
  assign w_clr        = (w_ctl_wr && sel_i[1]) ? dat_i[10:8] : 3'b000;
  assign w_unused     = ^{dat_i[23:11], dat_i[7:2], sel_i[2]};

  assign w_rx_empty   = (r_rxf_cnt == '0);
  assign w_rx_full    = (r_rxf_cnt == DEPTH_C);
  assign w_tx_empty   = (r_txf_cnt == '0);
  assign w_tx_full    = (r_txf_cnt == DEPTH_C);
  assign w_tx_idle    = w_tx_empty && (r_tx_st == S_IDLE);
  assign w_rx_head    = r_rxf_mem[r_rxf_rp];
  assign w_tx_head    = r_txf_mem[r_txf_rp];

  assign w_rx_pop     = w_rx_pop_req & ~w_rx_empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_rx_push_ok = w_rx_push & (~w_rx_full | w_rx_pop);
  assign w_tx_push_ok = w_tx_push & (~w_tx_full | w_tx_pop);

  assign dat_o = r_dat;
  assign ack_o = r_ack;
  assign tx_o  = r_tx_o;
  assign int_o = (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_idle);

  always_comb begin
    w_rdata = '0;
    if (!adr2_i) begin
      if (sel_i[3] && !w_rx_empty) w_rdata[31:24] = w_rx_head;
      w_rdata[22] = w_tx_idle;
      w_rdata[21] = w_tx_idle;
      w_rdata[16] = ~w_rx_empty;
    end else begin
      w_rdata[0]     = r_rx_ie;
      w_rdata[1]     = r_tx_ie;
      w_rdata[8]     = r_rx_ovr;
      w_rdata[9]     = r_frm_err;
      w_rdata[10]    = r_tx_ovf;
      w_rdata[11]    = w_rx_full;
      w_rdata[12]    = w_tx_full;
      w_rdata[19:16] = sat4(r_rxf_cnt);
      w_rdata[27:24] = sat4(r_txf_cnt);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_rx_ie   <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_frm_err <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat <= w_rdata;
      if (w_ctl_wr && sel_i[0]) begin
        r_rx_ie <= dat_i[0];
        r_tx_ie <= dat_i[1];
      end
      r_rx_ovr  <= (r_rx_ovr & ~w_clr[0]) | (w_rx_push & w_rx_full & ~w_rx_pop);
      r_frm_err <= (r_frm_err & ~w_clr[1]) | w_rx_frm;
      r_tx_ovf  <= (r_tx_ovf & ~w_clr[2]) | (w_tx_push & w_tx_full & ~w_tx_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rxf_wp  <= '0;
      r_rxf_rp  <= '0;
      r_rxf_cnt <= '0;
      r_txf_wp  <= '0;
      r_txf_rp  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_rx_push_ok) r_rxf_wp <= r_rxf_wp + AW'(1);
      if (w_rx_pop)     r_rxf_rp <= r_rxf_rp + AW'(1);
      case ({w_rx_push_ok, w_rx_pop})
        2'b10:   r_rxf_cnt <= r_rxf_cnt + CW'(1);
        2'b01:   r_rxf_cnt <= r_rxf_cnt - CW'(1);
        default: ;
      endcase
      if (w_tx_push_ok) r_txf_wp <= r_txf_wp + AW'(1);
      if (w_tx_pop)     r_txf_rp <= r_txf_rp + AW'(1);
      case ({w_tx_push_ok, w_tx_pop})
        2'b10:   r_txf_cnt <= r_txf_cnt + CW'(1);
        2'b01:   r_txf_cnt <= r_txf_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by pointers and counts.
  always_ff @(posedge clk_i) begin
    if (w_rx_push_ok) r_rxf_mem[r_rxf_wp] <= r_rx_sh;
    if (w_tx_push_ok) r_txf_mem[r_txf_wp] <= dat_i[31:24];
    if (w_rx_sample) r_rx_sh <= {w_rx_line, r_rx_sh[7:1]};
    if (w_tx_pop)
      r_tx_sh <= w_tx_head;
    else if (r_tx_st == S_DATA && w_tx_tick)
      r_tx_sh <= {1'b0, r_tx_sh[7:1]};
  end

  // Receiver: r_rx_p1 is the synchronized line, r_rx_p2 its previous value.
  assign w_rx_line = r_rx_p1;
  assign w_rx_tick = (r_rx_st == S_START) ? (r_rx_cnt == HALF_LAST)
                   : ((r_rx_st == S_DATA || r_rx_st == S_STOP) && r_rx_cnt == BIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_p0  <= 1'b1;
      r_rx_p1  <= 1'b1;
      r_rx_p2  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
    end else begin
      r_rx_p0  <= rx_i;
      r_rx_p1  <= r_rx_p0;
      r_rx_p2  <= r_rx_p1;
      r_rx_st  <= w_rx_nx;
      r_rx_cnt <= (w_rx_tick || r_rx_st == S_IDLE || r_rx_st == S_WAIT) ? '0 : r_rx_cnt + 16'd1;
      r_rx_bit <= (r_rx_st != S_DATA) ? '0 : (w_rx_tick ? r_rx_bit + 3'd1 : r_rx_bit);
    end
  end

  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      S_IDLE:  if (r_rx_p2 && !w_rx_line) w_rx_nx = S_START;
      S_START: if (w_rx_tick) w_rx_nx = w_rx_line ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nx = S_STOP;
      S_STOP:  if (w_rx_tick) w_rx_nx = w_rx_line ? S_IDLE : S_WAIT;
      S_WAIT:  if (w_rx_line) w_rx_nx = S_IDLE;
      default: w_rx_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_sample = 1'b0;
    w_rx_push   = 1'b0;
    w_rx_frm    = 1'b0;
    case (r_rx_st)
      S_DATA: w_rx_sample = w_rx_tick;
      S_STOP: begin
        w_rx_push = w_rx_tick & w_rx_line;
        w_rx_frm  = w_rx_tick & ~w_rx_line;
      end
      default: ;
    endcase
  end

  // Transmitter: tx_o is the registered copy of the per-state line level.
  assign w_tx_tick = (r_tx_st != S_IDLE) && (r_tx_cnt == BIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_o   <= 1'b1;
    end else begin
      r_tx_st  <= w_tx_nx;
      r_tx_cnt <= (w_tx_tick || r_tx_st == S_IDLE) ? '0 : r_tx_cnt + 16'd1;
      r_tx_bit <= (r_tx_st != S_DATA) ? '0 : (w_tx_tick ? r_tx_bit + 3'd1 : r_tx_bit);
      r_tx_o   <= w_tx_line;
    end
  end

  always_comb begin
    w_tx_nx = r_tx_st;
    case (r_tx_st)
      S_IDLE:  if (!w_tx_empty) w_tx_nx = S_START;
      S_START: if (w_tx_tick) w_tx_nx = S_DATA;
      S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nx = S_STOP;
      S_STOP:  if (w_tx_tick) w_tx_nx = S_IDLE;
      default: w_tx_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop  = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_st)
      S_IDLE:  w_tx_pop  = ~w_tx_empty;
      S_START: w_tx_line = 1'b0;
      S_DATA:  w_tx_line = r_tx_sh[0];
      default: w_tx_line = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: bus access, TX/RX framing, FIFO limits,
// sticky flags, interrupt and asynchronous reset behaviour.
module tb_uart_fifo_core;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk, rst, stb, we, adr2, rx;
  logic [3:0]  sel;
  logic [31:0] dat_w, dat_r;
  logic        ack, tx, irq;
  int          errors, checks, cyc;

  uart_fifo_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr2_i(adr2), .dat_i(dat_w), .dat_o(dat_r), .ack_o(ack),
    .rx_i(rx), .tx_o(tx), .int_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic w, input logic a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    stb = 1'b1; we = w; adr2 = a; sel = s; dat_w = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    chk("ack", 32'(ack), 32'd1);
    q = dat_r;
  endtask

  task automatic wr(input logic a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, s, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic a, input logic [31:0] exp);
    logic [31:0] q;
    bus(1'b0, a, 4'hF, 32'h0, q);
    chk(tag, q, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopb;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Waits for a start bit, then samples each of the 10 bit cells near its centre.
  task automatic grab_frame(output logic [9:0] fr, output int t0);
    int n;
    n  = 0;
    fr = '1;
    @(negedge clk);
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_seen", 32'(n < 3000), 32'd1);
    t0 = cyc;
    if (n < 3000) begin
      repeat (CPB / 2 - 1) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        fr[i] = tx;
        if (i < 9) repeat (CPB) @(negedge clk);
      end
    end
  endtask

  task automatic count_low(input int ncyc, output int zeros);
    zeros = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
  endtask

  initial begin
    logic [9:0]  f0, f1;
    logic [9:0]  fr [5];
    logic [7:0]  b;
    logic [3:0]  pat;
    logic [31:0] d2;
    int          t0, t1, tt, zeros;

    errors = 0; checks = 0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr2 = 1'b0; sel = 4'h0; dat_w = '0; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_r, 32'h0);
    chk("rst_int", 32'(irq), 32'd0);
    rst = 1'b0;
    rd_chk("rst_ctrl", 1'b1, 32'h0000_0000);
    rd_chk("rst_data", 1'b0, 32'h0060_0000);

    // TX ordering and back-to-back spacing
    fork
      begin
        grab_frame(f0, t0);
        grab_frame(f1, t1);
      end
      begin
        wr(1'b0, 4'hF, 32'h5500_0000);
        wr(1'b0, 4'hF, 32'hA300_0000);
      end
    join
    chk("tx_frame_55", 32'(f0), 32'({1'b1, 8'h55, 1'b0}));
    chk("tx_frame_a3", 32'(f1), 32'({1'b1, 8'hA3, 1'b0}));
    chk("tx_frame_period", 32'(t1 - t0), 32'(10 * CPB + 1));
    rd_chk("tx_busy_stop", 1'b0, 32'h0000_0000);
    repeat (20) @(negedge clk);
    rd_chk("tx_idle_after", 1'b0, 32'h0060_0000);
    rd_chk("tx_count_zero", 1'b1, 32'h0000_0000);

    // RX fill and overrun
    for (int i = 0; i < 5; i++) begin
      b = 8'h11 + 8'(i);
      send_rx(b, 1'b1);
    end
    rd_chk("rx_full_ovr", 1'b1, 32'h0004_0900);
    for (int i = 0; i < 4; i++) begin
      b = 8'h11 + 8'(i);
      rd_chk("rx_pop", 1'b0, {b, 24'h61_0000});
    end
    rd_chk("rx_empty_read", 1'b0, 32'h0060_0000);
    wr(1'b1, 4'h2, 32'h0000_0100);
    rd_chk("rx_ovr_clear", 1'b1, 32'h0000_0000);

    // Framing error
    send_rx(8'h7E, 1'b0);
    rd_chk("frm_err_set", 1'b1, 32'h0000_0200);
    wr(1'b1, 4'h1, 32'h0000_0200);
    rd_chk("frm_err_keep", 1'b1, 32'h0000_0200);
    wr(1'b1, 4'h2, 32'h0000_0200);
    rd_chk("frm_err_clear", 1'b1, 32'h0000_0000);
    send_rx(8'h3C, 1'b1);
    rd_chk("rx_after_frm", 1'b0, 32'h3C61_0000);

    // TX overflow: one frame in flight, four queued, one dropped
    fork
      begin
        for (int k = 0; k < 5; k++) grab_frame(fr[k], tt);
      end
      begin
        wr(1'b0, 4'hF, 32'h0100_0000);
        for (int j = 2; j <= 6; j++) begin
          b = 8'(j);
          wr(1'b0, 4'hF, {b, 24'h0});
        end
        rd_chk("tx_ovf_ctrl", 1'b1, 32'h0400_1400);
      end
    join
    for (int k = 0; k < 5; k++) begin
      b = 8'(k + 1);
      chk("tx_ovf_frame", 32'(fr[k]), 32'({1'b1, b, 1'b0}));
    end
    count_low(400, zeros);
    chk("tx_no_sixth_frame", 32'(zeros), 32'd0);
    wr(1'b1, 4'h2, 32'h0000_0400);
    rd_chk("tx_ovf_clear", 1'b1, 32'h0000_0000);

    // Interrupt and ack alternation
    wr(1'b1, 4'h1, 32'h0000_0001);
    chk("int_rx_empty", 32'(irq), 32'd0);
    send_rx(8'h5A, 1'b1);
    chk("int_rx_raised", 32'(irq), 32'd1);
    rd_chk("int_rx_data", 1'b0, 32'h5A61_0000);
    chk("int_rx_lowered", 32'(irq), 32'd0);
    send_rx(8'hC3, 1'b1);
    send_rx(8'h3C, 1'b1);
    send_rx(8'h99, 1'b1);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr2 = 1'b0; sel = 4'hF;
    pat = '0; d2 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = {pat[2:0], ack};
      if (i == 2) d2 = dat_r;
    end
    stb = 1'b0;
    chk("ack_alternate", 32'(pat), 32'h0000_000A);
    chk("ack_second_pop", d2, 32'h3C61_0000);
    rd_chk("ack_two_pops", 1'b1, 32'h0001_0001);
    rd_chk("ack_remaining", 1'b0, 32'h9961_0000);
    wr(1'b1, 4'h1, 32'h0000_0003);
    chk("int_tx_idle", 32'(irq), 32'd1);

    // Asynchronous reset in the middle of a TX data bit
    wr(1'b0, 4'hF, 32'h0000_0000);
    wr(1'b0, 4'hF, 32'h0000_0000);
    repeat (30) @(negedge clk);
    chk("pre_rst_tx_low", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_dat", dat_r, 32'h0);
    chk("async_rst_int", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("post_rst_ctrl", 1'b1, 32'h0000_0000);
    rd_chk("post_rst_data", 1'b0, 32'h0060_0000);
    count_low(200, zeros);
    chk("post_rst_no_resume", 32'(zeros), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
